twelve_hour_clock_core: RTL and testbench

- Synthesizable 12-hour clock core with an `ap_ctrl_hs` block-level handshake.
- Each accepted `ap_start` transaction either advances the held time by one second or loads a new time.
- It is the design under test that drives `ap_start`/`ap_ready`/`ap_done` into the sim-side module-status monitor.
- Time is held as hours 1–12, minutes, seconds and an AM/PM flag.

---
 rtl/twelve_hour_clock_core.sv | 197 +++++++++++++++++++
 tb/tb_twelve_hour_clock_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/twelve_hour_clock_core.sv
// twelve_hour_clock_core
// 12-hour time-of-day core driven by an ap_ctrl_hs block-level handshake.
// Each accepted ap_start either advances the held time by one second or
// loads a new time. The carry ripples through SEC -> MIN -> HR, so a
// transaction takes 2 to 4 cycles from acceptance to ap_done.
// Optional feature macro: CLOCK_ALARM_EN (alarm compare on the committed time).
module twelve_hour_clock_core (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic       ap_start,
    output logic       ap_done,
    output logic       ap_ready,
    output logic       ap_idle,
    input  logic       set_en,
    input  logic [3:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       set_pm,
    input  logic [3:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_pm,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       pm,
    output logic       set_err,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEC  = 3'd1,
        MIN  = 3'd2,
        HR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Working copy of the time; the visible outputs only follow it on DONE
    logic [3:0] w_h;
    logic [5:0] w_m;
    logic [5:0] w_s;
    logic       w_pm;
    logic [3:0] w_h_nxt;
    logic [5:0] w_m_nxt;
    logic [5:0] w_s_nxt;
    logic       w_pm_nxt;

    // Request captured at acceptance so the inputs may change afterwards
    logic       req_set;
    logic [3:0] req_hour;
    logic [5:0] req_min;
    logic [5:0] req_sec;
    logic       req_pm;

    logic       load_ok;
    logic       err_nxt;
    logic       alarm_nxt;

    assign load_ok = (req_hour >= 4'd1) && (req_hour <= 4'd12) &&
                     (req_min <= 6'd59) && (req_sec <= 6'd59);

    assign ap_done  = (state == DONE);
    assign ap_ready = (state == DONE);
    assign ap_idle  = (state == IDLE);

    // Next-state and working-register update, one carry stage per state
    always_comb begin
        state_nxt = state;
        w_h_nxt   = w_h;
        w_m_nxt   = w_m;
        w_s_nxt   = w_s;
        w_pm_nxt  = w_pm;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    state_nxt = SEC;
                end
            end
            SEC: begin
                state_nxt = DONE;
                if (req_set) begin
                    if (load_ok) begin
                        w_h_nxt  = req_hour;
                        w_m_nxt  = req_min;
                        w_s_nxt  = req_sec;
                        w_pm_nxt = req_pm;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (w_s < 6'd59) begin
                    w_s_nxt = w_s + 6'd1;
                end else begin
                    w_s_nxt   = 6'd0;
                    state_nxt = MIN;
                end
            end
            MIN: begin
                if (w_m < 6'd59) begin
                    w_m_nxt   = w_m + 6'd1;
                    state_nxt = DONE;
                end else begin
                    w_m_nxt   = 6'd0;
                    state_nxt = HR;
                end
            end
            HR: begin
                state_nxt = DONE;
                if (w_h == 4'd11) begin
                    w_h_nxt  = 4'd12;
                    w_pm_nxt = ~w_pm;
                end else if (w_h == 4'd12) begin
                    w_h_nxt = 4'd1;
                end else begin
                    w_h_nxt = w_h + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef CLOCK_ALARM_EN
    // Alarm fires when the time being committed lands on alarm_hour:alarm_min:00
    assign alarm_nxt = (state_nxt == DONE) && !err_nxt &&
                       (w_h_nxt == alarm_hour) && (w_m_nxt == alarm_min) &&
                       (w_s_nxt == 6'd0) && (w_pm_nxt == alarm_pm);
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = ^{alarm_hour, alarm_min, alarm_pm};
    assign alarm_nxt = 1'b0;
`endif

    // State and working time; reset returns to 12:00:00 AM and aborts any transaction
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            w_h   <= 4'd12;
            w_m   <= 6'd0;
            w_s   <= 6'd0;
            w_pm  <= 1'b0;
        end else begin
            state <= state_nxt;
            w_h   <= w_h_nxt;
            w_m   <= w_m_nxt;
            w_s   <= w_s_nxt;
            w_pm  <= w_pm_nxt;
        end
    end

    // Capture the load request together with ap_start while idle
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            req_set  <= 1'b0;
            req_hour <= 4'd0;
            req_min  <= 6'd0;
            req_sec  <= 6'd0;
            req_pm   <= 1'b0;
        end else if (state == IDLE && ap_start) begin
            req_set  <= set_en;
            req_hour <= set_hour;
            req_min  <= set_min;
            req_sec  <= set_sec;
            req_pm   <= set_pm;
        end
    end

    // Visible time and status flags update only on the edge that enters DONE
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            hours   <= 4'd12;
            minutes <= 6'd0;
            seconds <= 6'd0;
            pm      <= 1'b0;
            set_err <= 1'b0;
            alarm   <= 1'b0;
        end else if (state_nxt == DONE) begin
            hours   <= w_h_nxt;
            minutes <= w_m_nxt;
            seconds <= w_s_nxt;
            pm      <= w_pm_nxt;
            set_err <= err_nxt;
            alarm   <= alarm_nxt;
        end else begin
            set_err <= 1'b0;
            alarm   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_twelve_hour_clock_core.sv
// tb_twelve_hour_clock_core
// Directed bench for twelve_hour_clock_core with hand-computed expected times,
// handshake latencies, error and alarm pulses. Alarm expectations follow
// CLOCK_ALARM_EN so the bench suits both builds.
module tb_twelve_hour_clock_core;

    logic       ap_clk;
    logic       ap_rst_n;
    logic       ap_start;
    logic       ap_done;
    logic       ap_ready;
    logic       ap_idle;
    logic       set_en;
    logic [3:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_pm;
    logic [3:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_pm;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pm;
    logic       set_err;
    logic       alarm;

    int errors = 0;
    int checks = 0;

`ifdef CLOCK_ALARM_EN
    localparam int ALARM_ON = 1;
`else
    localparam int ALARM_ON = 0;
`endif

    twelve_hour_clock_core dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_ready   (ap_ready),
        .ap_idle    (ap_idle),
        .set_en     (set_en),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .set_pm     (set_pm),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_pm   (alarm_pm),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .pm         (pm),
        .set_err    (set_err),
        .alarm      (alarm)
    );

    // Free-running 100 MHz clock
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge ap_clk);
        #1;
    endtask

    // Run one transaction from IDLE and check latency, committed time and flags
    task automatic applyStimulus(input string tag, input logic isSet,
                                 input int h, input int m, input int s, input int p,
                                 input int expH, input int expM, input int expS, input int expPm,
                                 input int expLat, input int expErr, input int expAlarm);
        int lat;
        set_en   = isSet;
        set_hour = 4'(h);
        set_min  = 6'(m);
        set_sec  = 6'(s);
        set_pm   = p[0];
        ap_start = 1'b1;
        stepCycle();
        ap_start = 1'b0;
        set_en   = 1'b0;
        checkOutput({tag, "_idle_low"}, int'(ap_idle), 0);
        lat = 1;
        while (ap_done !== 1'b1 && lat < 8) begin
            stepCycle();
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_ready"}, int'(ap_ready), 1);
        checkOutput({tag, "_hours"}, int'(hours), expH);
        checkOutput({tag, "_minutes"}, int'(minutes), expM);
        checkOutput({tag, "_seconds"}, int'(seconds), expS);
        checkOutput({tag, "_pm"}, int'(pm), expPm);
        checkOutput({tag, "_set_err"}, int'(set_err), expErr);
        checkOutput({tag, "_alarm"}, int'(alarm), expAlarm);
        stepCycle();
        checkOutput({tag, "_idle_back"}, int'(ap_idle), 1);
        checkOutput({tag, "_done_once"}, int'(ap_done), 0);
    endtask

    initial begin
        int doneCount;
        int cyc;
        ap_rst_n   = 1'b0;
        ap_start   = 1'b0;
        set_en     = 1'b0;
        set_hour   = 4'd0;
        set_min    = 6'd0;
        set_sec    = 6'd0;
        set_pm     = 1'b0;
        alarm_hour = 4'd7;
        alarm_min  = 6'd30;
        alarm_pm   = 1'b0;

        $display("[TB] reset");
        repeat (3) stepCycle();
        ap_rst_n = 1'b1;
        stepCycle();
        checkOutput("rst_hours", int'(hours), 12);
        checkOutput("rst_minutes", int'(minutes), 0);
        checkOutput("rst_seconds", int'(seconds), 0);
        checkOutput("rst_pm", int'(pm), 0);
        checkOutput("rst_idle", int'(ap_idle), 1);
        checkOutput("rst_done", int'(ap_done), 0);
        checkOutput("rst_err", int'(set_err), 0);

        $display("[TB] simple tick");
        applyStimulus("ld_031520p", 1'b1, 3, 15, 20, 1, 3, 15, 20, 1, 2, 0, 0);
        applyStimulus("tk_031521p", 1'b0, 0, 0, 0, 0, 3, 15, 21, 1, 2, 0, 0);

        $display("[TB] minute carry");
        applyStimulus("ld_031559p", 1'b1, 3, 15, 59, 1, 3, 15, 59, 1, 2, 0, 0);
        applyStimulus("tk_031600p", 1'b0, 0, 0, 0, 0, 3, 16, 0, 1, 3, 0, 0);

        $display("[TB] hour carry");
        applyStimulus("ld_115959a", 1'b1, 11, 59, 59, 0, 11, 59, 59, 0, 2, 0, 0);
        applyStimulus("tk_120000p", 1'b0, 0, 0, 0, 0, 12, 0, 0, 1, 4, 0, 0);
        applyStimulus("ld_125959p", 1'b1, 12, 59, 59, 1, 12, 59, 59, 1, 2, 0, 0);
        applyStimulus("tk_010000p", 1'b0, 0, 0, 0, 0, 1, 0, 0, 1, 4, 0, 0);
        applyStimulus("ld_115959p", 1'b1, 11, 59, 59, 1, 11, 59, 59, 1, 2, 0, 0);
        applyStimulus("tk_120000a", 1'b0, 0, 0, 0, 0, 12, 0, 0, 0, 4, 0, 0);

        $display("[TB] invalid loads");
        applyStimulus("ld_050000a", 1'b1, 5, 0, 0, 0, 5, 0, 0, 0, 2, 0, 0);
        applyStimulus("bad_hour13", 1'b1, 13, 10, 10, 1, 5, 0, 0, 0, 2, 1, 0);
        applyStimulus("bad_hour0", 1'b1, 0, 10, 10, 1, 5, 0, 0, 0, 2, 1, 0);
        applyStimulus("bad_min60", 1'b1, 6, 60, 10, 1, 5, 0, 0, 0, 2, 1, 0);
        applyStimulus("bad_sec60", 1'b1, 6, 10, 60, 1, 5, 0, 0, 0, 2, 1, 0);

        $display("[TB] alarm");
        applyStimulus("ld_072959a", 1'b1, 7, 29, 59, 0, 7, 29, 59, 0, 2, 0, 0);
        applyStimulus("tk_073000a", 1'b0, 0, 0, 0, 0, 7, 30, 0, 0, 3, 0, ALARM_ON);
        applyStimulus("tk_073001a", 1'b0, 0, 0, 0, 0, 7, 30, 1, 0, 2, 0, 0);

        $display("[TB] back-to-back");
        applyStimulus("ld_010000p", 1'b1, 1, 0, 0, 1, 1, 0, 0, 1, 2, 0, 0);
        doneCount = 0;
        cyc = 0;
        set_en   = 1'b0;
        ap_start = 1'b1;
        while (doneCount < 10 && cyc < 100) begin
            stepCycle();
            cyc++;
            if (ap_done === 1'b1 || ap_ready === 1'b1) begin
                checkOutput("thru_ready_with_done", int'(ap_ready), int'(ap_done));
            end
            if (ap_done === 1'b1) begin
                doneCount++;
                if (doneCount == 10) begin
                    ap_start = 1'b0;
                end
            end
        end
        ap_start = 1'b0;
        checkOutput("thru_cycles", cyc, 29);
        repeat (6) begin
            stepCycle();
            if (ap_done === 1'b1) begin
                doneCount++;
            end
        end
        checkOutput("thru_done_count", doneCount, 10);
        checkOutput("thru_seconds", int'(seconds), 10);
        checkOutput("thru_idle", int'(ap_idle), 1);

        $display("[TB] reset during hour carry");
        applyStimulus("ld_105959p", 1'b1, 10, 59, 59, 1, 10, 59, 59, 1, 2, 0, 0);
        set_en   = 1'b0;
        ap_start = 1'b1;
        stepCycle();
        ap_start = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("midhr_done", int'(ap_done), 0);
        checkOutput("midhr_hours_stable", int'(hours), 10);
        checkOutput("midhr_seconds_stable", int'(seconds), 59);
        ap_rst_n = 1'b0;
        repeat (2) begin
            stepCycle();
            checkOutput("midhr_rst_done", int'(ap_done), 0);
        end
        ap_rst_n = 1'b1;
        repeat (4) begin
            stepCycle();
            checkOutput("midhr_post_done", int'(ap_done), 0);
        end
        checkOutput("midhr_hours", int'(hours), 12);
        checkOutput("midhr_minutes", int'(minutes), 0);
        checkOutput("midhr_seconds", int'(seconds), 0);
        checkOutput("midhr_pm", int'(pm), 0);
        checkOutput("midhr_idle", int'(ap_idle), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
